// File: rtl/maxpool_window_feeder_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_window_feeder_pkg
// Shared project macros and the types/constants used by the max-pooling
// window feeder, its bus interface and its address generator.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef MAXPOOL_PROJECT_DEFINES
`define MAXPOOL_PROJECT_DEFINES
`define DATA_BITS 16
`define MAX_NUM_1 4
`define TRUE      1'b1
`define FALSE     1'b0
`define IMG_W     64
`define OUT_W     32
`define CNT_IDLE  15
`endif

package maxpool_window_feeder_pkg;

    localparam int DW = `DATA_BITS;

    typedef logic signed [DW-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Window schedule: phases 0..3 issue reads, 1..4 stream pixels,
    // 5 flushes the pooling unit, 6 samples its result.
    localparam logic [2:0] PH_LAST_RD  = 3'd3;
    localparam logic [2:0] PH_LAST_PIX = 3'd4;
    localparam logic [2:0] PH_FLUSH    = 3'd5;
    localparam logic [2:0] PH_SAMPLE   = 3'd6;

    localparam logic [3:0] CNT_FLUSH = 4'(`MAX_NUM_1);
    localparam logic [3:0] CNT_IDLE  = 4'(`CNT_IDLE);

endpackage

// File: rtl/maxpool_window_feeder_if.sv
// -----------------------------------------------------------------------------
// maxpool_window_feeder_if
// Bundles the controller handshake, layer-0 read port, pooling-unit stream
// and layer-1 write port of the window feeder.
//   master : the feeder (drives busy/done, read address, pixel stream, write)
//   slave  : the environment (controller, memories, pooling unit)
// -----------------------------------------------------------------------------
interface maxpool_window_feeder_if #(
    parameter int RD_AW = 12,
    parameter int WR_AW = 10
);
    import maxpool_window_feeder_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic [RD_AW-1:0] caddr_rd;
    pixel_t           cdata_rd;
    logic             pool_en;
    pixel_t           input_FM;
    logic [3:0]       input_counter;
    logic             max_done;
    pixel_t           max_output_pixel;
    logic             cwr;
    logic [WR_AW-1:0] caddr_wr;
    pixel_t           cdata_wr;
    logic             protocol_err;

    modport master (
        input  start, cdata_rd, max_done, max_output_pixel,
        output busy, done, caddr_rd, pool_en, input_FM, input_counter,
               cwr, caddr_wr, cdata_wr, protocol_err
    );

    modport slave (
        output start, cdata_rd, max_done, max_output_pixel,
        input  busy, done, caddr_rd, pool_en, input_FM, input_counter,
               cwr, caddr_wr, cdata_wr, protocol_err
    );

endinterface

// File: rtl/maxpool_window_feeder_pool_addr_gen.sv
// -----------------------------------------------------------------------------
// pool_addr_gen
// Combinational map from a 2x2 window index and slot k to the linear read
// address of that pixel in an IMG_W x IMG_W map.
//   win  : window index, row-major over an OUT_W x OUT_W grid
//   k    : slot in window, k[1] = row offset, k[0] = column offset
//   addr : (2r+k[1])*IMG_W + (2c+k[0])
// -----------------------------------------------------------------------------
module pool_addr_gen #(
    parameter int IMG_W  = 64,
    parameter int OUT_W  = 32,
    parameter int RD_AW  = 12,
    parameter int WIN_AW = 10
) (
    input  logic [WIN_AW-1:0] win,
    input  logic [1:0]        k,
    output logic [RD_AW-1:0]  addr
);
    logic [RD_AW-1:0] row;
    logic [RD_AW-1:0] col;

    always_comb begin
        row  = RD_AW'(win / WIN_AW'(OUT_W));
        col  = RD_AW'(win % WIN_AW'(OUT_W));
        addr = ((row << 1) + RD_AW'(k[1])) * RD_AW'(IMG_W)
             + (col << 1) + RD_AW'(k[0]);
    end

endmodule

// File: rtl/maxpool_window_feeder.sv
// -----------------------------------------------------------------------------
// maxpool_window_feeder
// Walks the layer-0 map in 2x2 windows, streams each window's four pixels
// into the max-pooling unit and writes each pooled result to layer-1 memory.
//   clk   : system clock
//   reset : asynchronous active-high reset, aborts a frame with no write
//   bus   : master side of maxpool_window_feeder_if (start/busy/done,
//           layer-0 read, pooling stream, layer-1 write, protocol_err)
// -----------------------------------------------------------------------------
module maxpool_window_feeder
    import maxpool_window_feeder_pkg::*;
#(
    parameter int IMG_W = `IMG_W,
    parameter int OUT_W = `OUT_W,
    parameter int RD_AW = 12,
    parameter int WR_AW = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    maxpool_window_feeder_if.master bus
);
    localparam logic [WR_AW-1:0] WIN_LAST = WR_AW'(OUT_W * OUT_W - 1);

    state_t           state, state_nx;
    logic [2:0]       phase, phase_nx;
    logic [WR_AW-1:0] win,   win_nx;

    logic             busy;
    logic             pool_en;
    pixel_t           input_fm;
    logic [3:0]       input_counter;
    logic             rd_en;
    logic [RD_AW-1:0] rd_addr;

    logic             wr_fire;
    logic             cwr_q;
    logic [WR_AW-1:0] caddr_wr_q;
    pixel_t           cdata_wr_q;
    logic             done_q;
    logic             err_q;

    pool_addr_gen #(
        .IMG_W (IMG_W),
        .OUT_W (OUT_W),
        .RD_AW (RD_AW),
        .WIN_AW(WR_AW)
    ) u_addr_gen (
        .win (win),
        .k   (phase[1:0]),
        .addr(rd_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            phase <= '0;
            win   <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            win   <= win_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        phase_nx      = phase;
        win_nx        = win;
        busy          = 1'b0;
        pool_en       = 1'b0;
        input_fm      = '0;
        input_counter = CNT_IDLE;
        rd_en         = 1'b0;
        wr_fire       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                    phase_nx = '0;
                    win_nx   = '0;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = (phase <= PH_LAST_RD);
                // Read data lags its address by one cycle, so slot k
                // arrives in phase k+1.
                if (phase >= 3'd1 && phase <= PH_LAST_PIX) begin
                    pool_en       = 1'b1;
                    input_fm      = bus.cdata_rd;
                    input_counter = 4'(phase - 3'd1);
                end else if (phase == PH_FLUSH) begin
                    pool_en       = 1'b1;
                    input_counter = CNT_FLUSH;
                end
                if (phase == PH_SAMPLE) begin
                    wr_fire  = 1'b1;
                    phase_nx = '0;
                    if (win == WIN_LAST) begin
                        state_nx = ST_IDLE;
                    end else begin
                        win_nx = win + WR_AW'(1);
                    end
                end else begin
                    phase_nx = phase + 3'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The write lands one cycle after sampling, overlapping phase 0 of the
    // next window (or the first idle cycle after the last one).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cwr_q      <= wr_fire;
            caddr_wr_q <= wr_fire ? win : '0;
            cdata_wr_q <= wr_fire ? bus.max_output_pixel : '0;
            done_q     <= wr_fire && (win == WIN_LAST);
            if (wr_fire && !bus.max_done) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done_q;
    assign bus.caddr_rd      = rd_en ? rd_addr : '0;
    assign bus.pool_en       = pool_en;
    assign bus.input_FM      = input_fm;
    assign bus.input_counter = input_counter;
    assign bus.cwr           = cwr_q;
    assign bus.caddr_wr      = caddr_wr_q;
    assign bus.cdata_wr      = cdata_wr_q;
    assign bus.protocol_err  = err_q;

endmodule

// File: tb/tb_maxpool_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_maxpool_window_feeder
// Self-checking bench: behavioural layer-0 memory and pooling unit around the
// feeder; a directed table for the first window plus per-cycle expectations
// derived from the window schedule.
// -----------------------------------------------------------------------------
module tb_maxpool_window_feeder;
    import maxpool_window_feeder_pkg::*;

    localparam int FRAME_CYC = 7 * 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic kill  = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int cur_idx    = 0;
    bit err_sticky = 1'b0;

    logic signed [15:0] mem [0:4095];
    logic signed [15:0] acc;
    logic               mdone_r;
    logic signed [15:0] mout;

    typedef struct {
        int addr;
        int pen;
        int cnt;
        int fm;
        int cwr;
        int waddr;
        int wdata;
    } vec_t;

    vec_t tbl [8];

    maxpool_window_feeder_if #(.RD_AW(12), .WR_AW(10)) bus ();

    maxpool_window_feeder #(
        .IMG_W(64),
        .OUT_W(32),
        .RD_AW(12),
        .WR_AW(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Layer-0 memory: one-cycle read latency.
    always @(posedge clk) bus.cdata_rd <= mem[bus.caddr_rd];

    // Pooling unit: running max floored at zero, result valid after flush.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mdone_r <= 1'b0;
            mout    <= '0;
        end else begin
            mdone_r <= 1'b0;
            if (bus.pool_en) begin
                if (bus.input_counter == 4'd0)
                    acc <= (bus.input_FM > 0) ? bus.input_FM : 16'sd0;
                else if (bus.input_counter < 4'd4)
                    acc <= (bus.input_FM > acc) ? bus.input_FM : acc;
                else if (bus.input_counter == 4'd4) begin
                    mdone_r <= 1'b1;
                    mout    <= acc;
                end
            end
        end
    end

    assign bus.max_done         = mdone_r & ~kill;
    assign bus.max_output_pixel = mout;

    function automatic int exp_addr(input int w, input int k);
        return (2 * (w / 32) + k / 2) * 64 + 2 * (w % 32) + k % 2;
    endfunction

    function automatic int exp_max(input int w);
        int m = 0;
        for (int k = 0; k < 4; k++) begin
            if (int'(mem[exp_addr(w, k)]) > m) m = int'(mem[exp_addr(w, k)]);
        end
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%0d required=%0d", name, cur_idx, act, exp);
        end
    endtask

    task automatic check_cycle(input int idx, input int kill_w);
        int w, ph;
        int e_addr, e_pen, e_cnt, e_fm, e_cwr, e_waddr, e_wdata, e_busy, e_done;
        cur_idx = idx;
        e_addr = 0; e_pen = 0; e_cnt = 15; e_fm = 0;
        e_cwr = 0; e_waddr = 0; e_wdata = 0; e_busy = 0; e_done = 0;
        if (idx < FRAME_CYC) begin
            w  = idx / 7;
            ph = idx % 7;
            e_busy = 1;
            if (ph <= 3) e_addr = exp_addr(w, ph);
            if (ph >= 1 && ph <= 4) begin
                e_pen = 1;
                e_cnt = ph - 1;
                e_fm  = int'(mem[exp_addr(w, ph - 1)]);
            end else if (ph == 5) begin
                e_pen = 1;
                e_cnt = 4;
            end
            if (ph == 0 && w > 0) begin
                e_cwr   = 1;
                e_waddr = w - 1;
                e_wdata = exp_max(w - 1);
            end
        end else if (idx == FRAME_CYC) begin
            e_cwr   = 1;
            e_waddr = 1023;
            e_wdata = exp_max(1023);
            e_done  = 1;
        end
        chk("caddr_rd", int'(bus.caddr_rd), e_addr);
        chk("pool_en", int'(bus.pool_en), e_pen);
        chk("input_counter", int'(bus.input_counter), e_cnt);
        chk("input_FM", int'(bus.input_FM), e_fm);
        chk("cwr", int'(bus.cwr), e_cwr);
        chk("caddr_wr", int'(bus.caddr_wr), e_waddr);
        chk("cdata_wr", int'(bus.cdata_wr), e_wdata);
        chk("busy", int'(bus.busy), e_busy);
        chk("done", int'(bus.done), e_done);
        chk("protocol_err", int'(bus.protocol_err),
            (err_sticky || (kill_w >= 0 && idx >= kill_w * 7 + 7)) ? 1 : 0);
    endtask

    // Pulses start, then checks ncyc cycles starting at phase 0 of window 0.
    task automatic run_frame(input int ncyc, input int kill_w, input int start_idx);
        @(negedge clk);
        bus.start = 1'b1;
        for (int idx = 0; idx < ncyc; idx++) begin
            @(negedge clk);
            check_cycle(idx, kill_w);
            if (idx < 8) begin
                chk("tbl_caddr_rd", int'(bus.caddr_rd), tbl[idx].addr);
                chk("tbl_pool_en", int'(bus.pool_en), tbl[idx].pen);
                chk("tbl_input_counter", int'(bus.input_counter), tbl[idx].cnt);
                chk("tbl_input_FM", int'(bus.input_FM), tbl[idx].fm);
                chk("tbl_cwr", int'(bus.cwr), tbl[idx].cwr);
                chk("tbl_caddr_wr", int'(bus.caddr_wr), tbl[idx].waddr);
                chk("tbl_cdata_wr", int'(bus.cdata_wr), tbl[idx].wdata);
            end
            kill      = (kill_w >= 0 && idx == kill_w * 7 + 6);
            bus.start = (idx == start_idx);
        end
        kill      = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        //          addr pen cnt  fm cwr waddr wdata
        tbl[0] = '{  0,  0, 15,  0,  0,  0,  0};
        tbl[1] = '{  1,  1,  0,  5,  0,  0,  0};
        tbl[2] = '{ 64,  1,  1,  9,  0,  0,  0};
        tbl[3] = '{ 65,  1,  2, -3,  0,  0,  0};
        tbl[4] = '{  0,  1,  3,  7,  0,  0,  0};
        tbl[5] = '{  0,  1,  4,  0,  0,  0,  0};
        tbl[6] = '{  0,  0, 15,  0,  0,  0,  0};
        tbl[7] = '{  2,  0, 15,  0,  1,  0,  9};

        for (int a = 0; a < 4096; a++) mem[a] = 16'(a);
        mem[0]  = 16'sd5;  mem[1]  = 16'sd9;  mem[64] = -16'sd3; mem[65] = 16'sd7;
        mem[2]  = -16'sd1; mem[3]  = -16'sd8; mem[66] = -16'sd2; mem[67] = -16'sd5;

        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        cur_idx = -1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pool_en", int'(bus.pool_en), 0);
        chk("rst_cwr", int'(bus.cwr), 0);
        chk("rst_protocol_err", int'(bus.protocol_err), 0);
        chk("rst_caddr_rd", int'(bus.caddr_rd), 0);
        chk("rst_caddr_wr", int'(bus.caddr_wr), 0);
        chk("rst_input_counter", int'(bus.input_counter), 15);
        reset = 1'b0;
        @(negedge clk);

        // Full frame: window 1 all negative, max_done dropped for window 3,
        // stray start at window 10 phase 2.
        run_frame(FRAME_CYC + 3, 3, 72);
        err_sticky = 1'b1;

        // Second frame aborted by reset at window 500 phase 4.
        run_frame(500 * 7 + 5, -1, -1);
        reset = 1'b1;
        #1;
        cur_idx = -2;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cwr", int'(bus.cwr), 0);
        chk("abort_pool_en", int'(bus.pool_en), 0);
        chk("abort_input_counter", int'(bus.input_counter), 15);
        chk("abort_caddr_rd", int'(bus.caddr_rd), 0);
        chk("abort_protocol_err", int'(bus.protocol_err), 0);
        err_sticky = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Restart after abort begins again at window 0.
        run_frame(16, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
